// File: rtl/windowed_register_file.sv
// Windowed register file: a 2^PHYS_AW-entry array seen through a 2^LOG_AW-entry window at WP.
// Storage is split into byte-lane slices; every state change happens on the falling clock edge.
module wrf_lane #(
  parameter int PHYS_AW = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [PHYS_AW-1:0] waddr,
  input  logic [PHYS_AW-1:0] laddr,
  input  logic [PHYS_AW-1:0] raddr,
  input  logic [7:0]         wdata,
  output logic [7:0]         lout,
  output logic [7:0]         rout
);
  localparam int NREG = 1 << PHYS_AW;

  logic [NREG-1:0][7:0] mem;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n)  mem        <= '0;
    else if (we) mem[waddr] <= wdata;
  end

  assign lout = mem[laddr];
  assign rout = mem[raddr];
endmodule

module windowed_register_file #(
  parameter int DATA_W  = 16,
  parameter int PHYS_AW = 6,
  parameter int LOG_AW  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   byte_we,
  input  logic [LOG_AW-1:0]     laddr,
  input  logic [LOG_AW-1:0]     raddr,
  input  logic                  wp_add,
  input  logic                  wp_clr,
  input  logic [PHYS_AW-1:0]    wp_imm,
  output logic [DATA_W-1:0]     lout,
  output logic [DATA_W-1:0]     rout,
  output logic [PHYS_AW-1:0]    wp_out
);
  localparam int NUM_LANES = DATA_W / 8;

  logic [PHYS_AW-1:0] wp, lphys, rphys;
  logic [NUM_LANES-1:0][7:0] wlane, llane, rlane;

  // Address sums are truncated to PHYS_AW bits, which gives the wrap past the top of the array.
  assign lphys = wp + PHYS_AW'(laddr);
  assign rphys = wp + PHYS_AW'(raddr);

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n)      wp <= '0;
    else if (wp_clr) wp <= '0;
    else if (wp_add) wp <= wp + wp_imm;
  end

  assign wp_out = wp;
  assign wlane  = wdata;
  assign lout   = llane;
  assign rout   = rlane;

  // The write address uses the pre-edge WP, so a write and a WP change in one edge stay independent.
  wrf_lane #(.PHYS_AW(PHYS_AW)) u_lane [NUM_LANES-1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (byte_we),
    .waddr (lphys),
    .laddr (lphys),
    .raddr (rphys),
    .wdata (wlane),
    .lout  (llane),
    .rout  (rlane)
  );
endmodule

// File: doc/windowed_register_file.md
Name: windowed_register_file

Overview:
- Parametrised successor to the fixed 4x16 SAYEH register file.
- Holds a large physical register array and exposes a small logical window of 2^LOG_AW registers, addressed relative to a window pointer (WP), with per-byte-lane write enables.
- Sits in the datapath between the ALU result bus and the ALU operand buses.
- The controller drives lane enables, window-pointer add/clear, and the left/right addresses.

Parameters:
- DATA_W, 16, register width in bits; must be a multiple of 8.
- PHYS_AW, 6, physical address width; the array holds 2^PHYS_AW registers.
- LOG_AW, 2, logical (window) address width; must be <= PHYS_AW.

Ports:
- clk  input  1  clock; all state updates on the falling edge.
- rst_n  input  1  asynchronous, active-low reset.
- wdata  input  DATA_W  write data.
- byte_we  input  DATA_W/8  per-lane write enable; bit k covers wdata[8k+7:8k]. For DATA_W=16, bit1 is the high byte and bit0 the low byte.
- laddr  input  LOG_AW  left logical address; read port L and the write target.
- raddr  input  LOG_AW  right logical address; read port R only.
- wp_add  input  1  add wp_imm to WP at the falling edge.
- wp_clr  input  1  clear WP to 0 at the falling edge.
- wp_imm  input  PHYS_AW  unsigned WP increment.
- lout  output  DATA_W  contents of physical register (WP+laddr).
- rout  output  DATA_W  contents of physical register (WP+raddr).
- wp_out  output  PHYS_AW  current window pointer.

Behaviour:
- Reset:
  - rst_n low asynchronously clears every physical register to 0 and WP to 0.
  - lout, rout and wp_out read 0 while rst_n is low and immediately after release.
  - A reset asserted mid-cycle overrides any pending write or WP update.
- Address translation:
  - phys = (WP + zero-extended logical addr) mod 2^PHYS_AW.
  - The window wraps past the top of the array: with WP=62, PHYS_AW=6, LOG_AW=2, logical 0..3 map to physical 62, 63, 0, 1.
- Reads:
  - Combinational from the array and the current WP; zero-cycle latency.
  - Both ports may address the same register.
- Writes:
  - At the falling edge of clk, each lane k with byte_we[k]=1 loads wdata lane k into the same lane of phys(laddr).
  - Lanes with byte_we[k]=0 hold their value.
  - byte_we all-zero is a hold; no register changes.
- Read-after-write:
  - A written value appears on lout/rout after the falling edge that stores it.
  - No same-cycle bypass: before that edge, the read ports show the old value.
- WP update, at the falling edge:
  - wp_clr=1: WP <= 0. wp_clr has priority over wp_add.
  - wp_add=1 (and wp_clr=0): WP <= (WP + wp_imm) mod 2^PHYS_AW.
  - Both low: WP holds.
- Simultaneous write and WP change at the same edge:
  - The write uses the old WP; the new WP takes effect for reads after the edge.
- wp_out always equals the internal WP register.
- Degenerate case: with LOG_AW = PHYS_AW and WP held at 0, the block is a plain register file with byte-lane writes.
- No X propagation from uninitialised storage: all storage is covered by reset.

Test Plan:
- Reset: drive rst_n=0 mid-cycle after writing 0xBEEF to phys 5 -> lout=rout=0x0000 and wp_out=0 immediately; all 64 registers read 0 after release.
- Byte lanes (WP=0): write laddr=1, wdata=0x1234, byte_we=11, then wdata=0xABCD with byte_we=01, then byte_we=10 with 0x5600 -> reads 0x1234, then 0x12CD, then 0x56CD. byte_we=00 with 0xFFFF leaves 0x56CD.
- Window relocation: write 0x1111 at laddr=2 (WP=0, phys 2); wp_add with wp_imm=2 -> raddr=0 reads 0x1111 and wp_out=2. wp_clr -> laddr=2 reads 0x1111 again.
- Wrap-around: wp_add wp_imm=62 from WP=0; write 0xA5A5 to laddr=3 -> phys 1 holds 0xA5A5. wp_clr and read laddr=1 -> 0xA5A5.
- Simultaneous events: with WP=4, assert byte_we=11, wdata=0x7777, laddr=0, wp_add=1, wp_imm=4 at the same edge -> phys 4 holds 0x7777 and WP=8. Then wp_add=1 with wp_clr=1 -> WP=0.
- Same-cycle read: with laddr=raddr=3 and a write of 0x0F0F pending, lout and rout show the old value before the falling edge and 0x0F0F after it.
